// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: round-robin sharing of one iterative binary-to-BCD converter with timeout watchdog
module bcd_convert_scheduler #(
  parameter int INPUT_WIDTH    = 7,
  parameter int DECIMAL_DIGITS = 2,
  parameter int NUM_REQ        = 2,
  parameter int ID_WIDTH       = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              i_Clock,
  input  logic                              i_Reset_n,
  input  logic [NUM_REQ-1:0]                i_Req_Valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]    i_Req_Binary,
  output logic [NUM_REQ-1:0]                o_Req_Ready,
  output logic                              o_Conv_Start,
  output logic [INPUT_WIDTH-1:0]            o_Conv_Binary,
  input  logic                              i_Conv_Done,
  input  logic [DECIMAL_DIGITS*4-1:0]       i_Conv_BCD,
  output logic                              o_Result_Valid,
  output logic [DECIMAL_DIGITS*4-1:0]       o_Result_BCD,
  output logic [ID_WIDTH-1:0]               o_Result_Id,
  output logic                              o_Result_Error,
  input  logic                              i_Result_Ready
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, START, WAIT, OUTPUT} state_t;
  state_t state, state_next;
  logic [ID_WIDTH-1:0] ptr, grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [INPUT_WIDTH-1:0] grant_bin;
  logic [15:0] timeout_cnt;
  logic found, transfer, expired;
  int idx;
  // first valid requester after the pointer, wrapping, picks grant, id and operand
  always_comb begin
    grant = '0;
    grant_id = '0;
    grant_bin = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && i_Req_Valid[IW'(idx)]) begin
        grant[IW'(idx)] = 1'b1;
        grant_id = ID_WIDTH'(idx);
        grant_bin = i_Req_Binary[idx*INPUT_WIDTH +: INPUT_WIDTH];
        found = 1'b1;
      end
    end
  end
  assign transfer = state == IDLE && found;
  assign expired = timeout_cnt == 16'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) state <= IDLE;
    else state <= state_next;
  end
  // next state and handshake outputs; done beats expiry in WAIT
  always_comb begin
    state_next = state;
    o_Req_Ready = '0;
    o_Conv_Start = 1'b0;
    o_Result_Valid = 1'b0;
    case (state)
      IDLE: begin
        o_Req_Ready = grant;
        state_next = found ? START : IDLE;
      end
      START: begin
        o_Conv_Start = 1'b1;
        state_next = WAIT;
      end
      WAIT: state_next = (i_Conv_Done || expired) ? OUTPUT : WAIT;
      OUTPUT: begin
        o_Result_Valid = 1'b1;
        state_next = i_Result_Ready ? IDLE : OUTPUT;
      end
      default: state_next = IDLE;
    endcase
  end
  // job capture, watchdog counter and result registers
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      ptr <= ID_WIDTH'(NUM_REQ - 1);
      o_Conv_Binary <= '0;
      o_Result_Id <= '0;
      o_Result_BCD <= '0;
      o_Result_Error <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      if (transfer) begin
        o_Conv_Binary <= grant_bin;
        o_Result_Id <= grant_id;
        ptr <= grant_id;
      end
      if (state == START) timeout_cnt <= '0;
      else if (state == WAIT) timeout_cnt <= timeout_cnt + 16'd1;
      if (state == WAIT && i_Conv_Done) begin
        o_Result_BCD <= i_Conv_BCD;
        o_Result_Error <= 1'b0;
      end else if (state == WAIT && expired) begin
        o_Result_BCD <= '1;
        o_Result_Error <= 1'b1;
      end
    end
  end
endmodule
